// File: rtl/pwm_generator_if.sv
// Bundle of signals between the pwm_generator, its upstream counter and its duty source.
// The slave modport is the generator's view; master is the driver/consumer side.
interface pwm_if #(
  parameter int T = 256
);
  localparam int W  = $clog2(T);
  localparam int DW = $clog2(T + 1);

  logic [W-1:0]  count;
  logic          en;
  logic [DW-1:0] duty;
  logic          duty_valid;
  logic          duty_ready;
  logic          pwm;
  logic          busy;
  logic          period_done;

  modport master (
    output count, en, duty, duty_valid,
    input  duty_ready, pwm, busy, period_done
  );

  modport slave (
    input  count, en, duty, duty_valid,
    output duty_ready, pwm, busy, period_done
  );
endinterface

// File: rtl/pwm_generator.sv
// Period-synchronous PWM generator driven by an external free-running counter.
// Duty changes go through a shadow register and apply only at a period boundary.
//
// state | meaning
// IDLE  | stopped, pwm low, waiting for en
// ARMED | en seen, pwm low, waiting for the first boundary to load duty
// RUN   | generating pwm, duty reloaded at every boundary
// DRAIN | en dropped, finishing the current period before stopping
module pwm_generator #(
  parameter int T = 256
) (
  input  logic clk,
  input  logic rst,
  pwm_if.slave bus
);
  localparam int W  = $clog2(T);
  localparam int DW = $clog2(T + 1);
  localparam logic [W-1:0]  LAST = W'(T - 1);
  localparam logic [DW-1:0] FULL = DW'(T);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] shadow, active, duty_clamped;
  logic          pending, pwm_r, done_r;
  logic          boundary, xfer, load, pwm_nxt, done_nxt, in_period;

  assign boundary     = (bus.count == LAST);
  assign xfer         = bus.duty_valid && !pending;
  assign duty_clamped = (bus.duty > FULL) ? FULL : bus.duty;
  // count is zero-extended so that count >= T naturally compares as low
  assign in_period    = (DW'(bus.count) < active);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pwm_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en) state_nxt = ARMED;
      end
      ARMED: begin
        if (!bus.en) begin
          state_nxt = IDLE;
        end else if (boundary) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        pwm_nxt = in_period;
        if (boundary) begin
          load     = 1'b1;
          done_nxt = 1'b1;
        end
        if (!bus.en) state_nxt = DRAIN;
      end
      DRAIN: begin
        pwm_nxt = in_period;
        if (boundary) begin
          load     = 1'b1;
          done_nxt = 1'b1;
        end
        if (bus.en) begin
          state_nxt = RUN;
        end else if (boundary) begin
          state_nxt = IDLE;
          pwm_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pwm_r   <= 1'b0;
      done_r  <= 1'b0;
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      state  <= state_nxt;
      pwm_r  <= pwm_nxt;
      done_r <= done_nxt;
      if (load) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      // a transfer on a load edge wins: the old shadow moves to active, the new one waits
      if (xfer) begin
        shadow  <= duty_clamped;
        pending <= 1'b1;
      end
    end
  end

  assign bus.duty_ready  = !pending;
  assign bus.pwm         = pwm_r;
  assign bus.busy        = (state != IDLE);
  assign bus.period_done = done_r;
endmodule

// File: tb/tb_pwm_generator.sv
// Directed testbench for pwm_generator with T=8 and a free-running upstream counter model.
// After step(), the edge just taken sampled the current bus.count value.
module tb_pwm_generator;
  localparam int T  = 8;
  localparam int W  = $clog2(T);
  localparam int DW = $clog2(T + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  pwm_if #(.T(T)) bus ();

  pwm_generator #(.T(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // upstream counter: changes 3 time units after each edge, so each edge sees a stable value
  initial begin
    bus.count = '0;
    forever begin
      @(posedge clk);
      #3;
      bus.count = (bus.count == W'(T - 1)) ? '0 : W'(bus.count + W'(1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    int n;
    n = 0;
    step();
    while (int'(bus.count) != c && n < 20) begin
      step();
      n++;
    end
    if (int'(bus.count) != c) begin
      nerr++;
      $display("FAIL goto: count=%0d, required %0d", bus.count, c);
    end
  endtask

  task automatic do_xfer(input int d);
    bus.duty       = DW'(d);
    bus.duty_valid = 1'b1;
    step();
    bus.duty_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    nvec++; if (bus.pwm !== 1'b0) begin nerr++; $display("FAIL reset_pwm: got %b want 0", bus.pwm); end
    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    nvec++; if (bus.period_done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", bus.period_done); end
    nvec++; if (bus.duty_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", bus.duty_ready); end
  endtask

  task automatic test_start;
    logic ep, ed;
    do_xfer(3);
    nvec++; if (bus.duty_ready !== 1'b0) begin nerr++; $display("FAIL idle_ready: got %b want 0", bus.duty_ready); end
    goto(4);
    bus.en = 1'b1;
    step();
    nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL armed_busy: got %b want 1", bus.busy); end
    step();
    nvec++; if (bus.pwm !== 1'b0) begin nerr++; $display("FAIL armed_pwm: got %b want 0", bus.pwm); end
    step();
    nvec++; if (bus.duty_ready !== 1'b1) begin nerr++; $display("FAIL load_ready: got %b want 1", bus.duty_ready); end
    nvec++; if (bus.pwm !== 1'b0) begin nerr++; $display("FAIL load_pwm: got %b want 0", bus.pwm); end
    nvec++; if (bus.period_done !== 1'b0) begin nerr++; $display("FAIL load_done: got %b want 0", bus.period_done); end
    for (int i = 0; i < 16; i++) begin
      step();
      ep = (int'(bus.count) < 3);
      ed = (int'(bus.count) == 7);
      nvec++; if (bus.pwm !== ep) begin nerr++; $display("FAIL run3_pwm: count=%0d got %b want %b", bus.count, bus.pwm, ep); end
      nvec++; if (bus.period_done !== ed) begin nerr++; $display("FAIL run3_done: count=%0d got %b want %b", bus.count, bus.period_done, ed); end
    end
  endtask

  task automatic test_duty_change;
    logic ep;
    goto(1);
    do_xfer(6);
    nvec++; if (bus.duty_ready !== 1'b0) begin nerr++; $display("FAIL chg_ready: got %b want 0", bus.duty_ready); end
    nvec++; if (bus.pwm !== 1'b1) begin nerr++; $display("FAIL chg_pwm: got %b want 1", bus.pwm); end
    bus.duty       = DW'(1);
    bus.duty_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      ep = (int'(bus.count) < 3);
      nvec++; if (bus.duty_ready !== 1'b0) begin nerr++; $display("FAIL chg_hold_ready: count=%0d got %b want 0", bus.count, bus.duty_ready); end
      nvec++; if (bus.pwm !== ep) begin nerr++; $display("FAIL chg_old_pwm: count=%0d got %b want %b", bus.count, bus.pwm, ep); end
    end
    bus.duty_valid = 1'b0;
    step();
    nvec++; if (bus.duty_ready !== 1'b1) begin nerr++; $display("FAIL chg_load_ready: got %b want 1", bus.duty_ready); end
    nvec++; if (bus.period_done !== 1'b1) begin nerr++; $display("FAIL chg_done: got %b want 1", bus.period_done); end
    for (int i = 0; i < 16; i++) begin
      step();
      ep = (int'(bus.count) < 6);
      nvec++; if (bus.pwm !== ep) begin nerr++; $display("FAIL run6_pwm: count=%0d got %b want %b", bus.count, bus.pwm, ep); end
    end
  endtask

  task automatic test_extremes;
    do_xfer(0);
    goto(7);
    for (int i = 0; i < 8; i++) begin
      step();
      nvec++; if (bus.pwm !== 1'b0) begin nerr++; $display("FAIL duty0_pwm: count=%0d got %b want 0", bus.count, bus.pwm); end
    end
    do_xfer(8);
    goto(7);
    for (int i = 0; i < 8; i++) begin
      step();
      nvec++; if (bus.pwm !== 1'b1) begin nerr++; $display("FAIL duty8_pwm: count=%0d got %b want 1", bus.count, bus.pwm); end
    end
    do_xfer(12);
    goto(7);
    for (int i = 0; i < 8; i++) begin
      step();
      nvec++; if (bus.pwm !== 1'b1) begin nerr++; $display("FAIL duty12_pwm: count=%0d got %b want 1", bus.count, bus.pwm); end
    end
  endtask

  task automatic test_stop;
    logic ep;
    do_xfer(3);
    goto(7);
    goto(3);
    bus.en = 1'b0;
    step();
    nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL drain_busy: got %b want 1", bus.busy); end
    nvec++; if (bus.pwm !== 1'b0) begin nerr++; $display("FAIL drain_pwm: got %b want 0", bus.pwm); end
    step();
    step();
    nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL drain_busy6: got %b want 1", bus.busy); end
    step();
    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL stop_busy: got %b want 0", bus.busy); end
    nvec++; if (bus.period_done !== 1'b1) begin nerr++; $display("FAIL stop_done: got %b want 1", bus.period_done); end
    nvec++; if (bus.pwm !== 1'b0) begin nerr++; $display("FAIL stop_pwm: got %b want 0", bus.pwm); end
    step();
    nvec++; if (bus.period_done !== 1'b0) begin nerr++; $display("FAIL stop_done_clr: got %b want 0", bus.period_done); end
    nvec++; if (bus.pwm !== 1'b0) begin nerr++; $display("FAIL idle_pwm: got %b want 0", bus.pwm); end
    bus.en = 1'b1;
    goto(7);
    goto(3);
    bus.en = 1'b0;
    step();
    nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL redrain_busy: got %b want 1", bus.busy); end
    goto(5);
    bus.en = 1'b1;
    step();
    step();
    nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL resume_busy: got %b want 1", bus.busy); end
    nvec++; if (bus.period_done !== 1'b1) begin nerr++; $display("FAIL resume_done: got %b want 1", bus.period_done); end
    for (int i = 0; i < 8; i++) begin
      step();
      ep = (int'(bus.count) < 3);
      nvec++; if (bus.pwm !== ep) begin nerr++; $display("FAIL resume_pwm: count=%0d got %b want %b", bus.count, bus.pwm, ep); end
      nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL resume_run_busy: count=%0d got %b want 1", bus.count, bus.busy); end
    end
  endtask

  task automatic test_async_reset;
    do_xfer(5);
    nvec++; if (bus.pwm !== 1'b1) begin nerr++; $display("FAIL pre_rst_pwm: got %b want 1", bus.pwm); end
    nvec++; if (bus.duty_ready !== 1'b0) begin nerr++; $display("FAIL pre_rst_ready: got %b want 0", bus.duty_ready); end
    #2;
    rst    = 1'b1;
    bus.en = 1'b0;
    #1;
    nvec++; if (bus.pwm !== 1'b0) begin nerr++; $display("FAIL arst_pwm: got %b want 0", bus.pwm); end
    nvec++; if (bus.duty_ready !== 1'b1) begin nerr++; $display("FAIL arst_ready: got %b want 1", bus.duty_ready); end
    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
    repeat (2) step();
    rst = 1'b0;
    do_xfer(0);
    bus.en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      nvec++; if (bus.pwm !== 1'b0) begin nerr++; $display("FAIL post_rst_pwm: count=%0d got %b want 0", bus.count, bus.pwm); end
    end
    nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL post_rst_busy: got %b want 1", bus.busy); end
  endtask

  initial begin
    bus.en         = 1'b0;
    bus.duty       = '0;
    bus.duty_valid = 1'b0;
    test_reset();
    test_start();
    test_duty_change();
    test_extremes();
    test_stop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
